// File: rtl/bsg_channel_token_pkg.sv
// Shared definitions for the token-counting channel link (transmit and
// receive ends). Both ends import the credit unit from here so they always
// agree on how many words a single token toggle represents.
package bsg_channel_token_pkg;

  localparam int default_channel_width_lp = 8;

  // One token toggle returns 2^lg_credit_decimation_lp credits.
  localparam int lg_credit_decimation_lp = 2;

  // Pointer width for an els-deep circular buffer. The extra bit above the
  // index distinguishes a full buffer from an empty one.
  function automatic int ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bsg_channel_token_rx_buf.sv
// Circular register-array FIFO, one write port and one read port.
// Ports:
//   clk_i, reset_n_i   clock, async active-low reset (clears pointers only)
//   enq_i, data_i      write data_i at the write pointer (caller guarantees !full_o)
//   deq_i              advance the read pointer (caller guarantees !empty_o)
//   data_o             head entry, read combinationally from storage
//   full_o, empty_o    occupancy flags
//   els_o              occupancy, 0..els_p
module bsg_channel_token_rx_buf
  import bsg_channel_token_pkg::*;
#(
  parameter int width_p = default_channel_width_lp,
  parameter int els_p   = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       deq_i,
  output logic [width_p-1:0]         data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(els_p+1)-1:0] els_o
);

  localparam int ptr_w_lp = ptr_width(els_p);
  localparam int idx_w_lp = $clog2(els_p);
  localparam int els_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [ptr_w_lp-1:0] occ;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq_i) wptr_r <= wptr_r + 1'b1;
      if (deq_i) rptr_r <= rptr_r + 1'b1;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_r[wptr_r[idx_w_lp-1:0]] <= data_i;
  end

  // els_p is a power of two, so the wrap-bit pointers count modulo 2*els_p
  // and their difference is the occupancy directly.
  assign occ     = wptr_r - rptr_r;
  assign full_o  = (occ == ptr_w_lp'(els_p));
  assign empty_o = (wptr_r == rptr_r);
  assign els_o   = els_w_lp'(occ);
  assign data_o  = mem_r[rptr_r[idx_w_lp-1:0]];

endmodule

// File: rtl/bsg_channel_token_rx.sv
// Receive end of one comm-link channel. Buffers incoming words, hands them
// to the core over valid/yumi, and returns credit to the sender by toggling
// token_o once per 2^lg_credit_decimation_p dequeued words.
// Ports:
//   clk_i, reset_n_i        clock, async active-low reset
//   io_valid_i, io_data_i   incoming word from the link
//   core_valid_o/data_o     head of buffer toward the core
//   core_yumi_i             core consumes the head word this cycle
//   token_o                 credit return line (registered)
//   overflow_o              sticky: a word arrived while the buffer was full
//   els_o                   current occupancy
module bsg_channel_token_rx
  import bsg_channel_token_pkg::*;
#(
  parameter int channel_width_p        = default_channel_width_lp,
  parameter int els_p                  = 16,
  parameter int lg_credit_decimation_p = lg_credit_decimation_lp
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       io_valid_i,
  input  logic [channel_width_p-1:0] io_data_i,
  output logic                       core_valid_o,
  output logic [channel_width_p-1:0] core_data_o,
  input  logic                       core_yumi_i,
  output logic                       token_o,
  output logic                       overflow_o,
  output logic [$clog2(els_p+1)-1:0] els_o
);

  logic full, empty;
  logic enq, deq;
  logic [lg_credit_decimation_p-1:0] decim_r;
  logic token_r, overflow_r;

  // Fullness is taken from the pre-cycle occupancy, so a word arriving at a
  // full buffer is dropped even if the core frees a slot in the same cycle.
  assign enq = io_valid_i & ~full;
  // A yumi while empty is illegal and simply ignored.
  assign deq = core_yumi_i & ~empty;

  bsg_channel_token_rx_buf #(
    .width_p (channel_width_p),
    .els_p   (els_p)
  ) buf_i (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (enq),
    .data_i    (io_data_i),
    .deq_i     (deq),
    .data_o    (core_data_o),
    .full_o    (full),
    .empty_o   (empty),
    .els_o     (els_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      decim_r    <= '0;
      token_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (deq) begin
        decim_r <= decim_r + 1'b1;
        if (&decim_r) token_r <= ~token_r;
      end
      if (io_valid_i && full) overflow_r <= 1'b1;
    end
  end

  assign core_valid_o = ~empty;
  assign token_o      = token_r;
  assign overflow_o   = overflow_r;

  always_ff @(posedge clk_i) begin
    if (reset_n_i && core_yumi_i) begin
      assert (core_valid_o) else $error("core_yumi_i asserted while buffer empty");
    end
  end

endmodule

// File: doc/bsg_channel_token_rx.md
Name: bsg_channel_token_rx

Overview:
- Receive end of one comm-link channel, the far-end counterpart of the token-counting channel transmitter.
- Accepts `channel_width_p`-bit words qualified by a valid bit and buffers them in a circular FIFO.
- Delivers words to the core over a valid/yumi interface.
- Returns flow-control credit by toggling a token line once per `2^lg_credit_decimation_p` dequeued words.
- The sender starts with `els_p` credits, so the buffer never legally overflows; an overflow is detected, the word is dropped, and a sticky flag is raised.

Parameters:
- channel_width_p, 8, width of one channel data word.
- els_p, 16, buffer depth; power of two, at least 4.
- lg_credit_decimation_p, 2, log2 of the number of dequeues represented by one token toggle; `2^lg_credit_decimation_p` must divide `els_p`.

Ports:
- clk_i  in  1  sole clock; io and core sides are both synchronous to it.
- reset_n_i  in  1  reset; asynchronous assert, active-low.
- io_valid_i  in  1  incoming word valid this cycle.
- io_data_i  in  channel_width_p  incoming word.
- core_valid_o  out  1  buffer non-empty.
- core_data_o  out  channel_width_p  head word; valid only while core_valid_o=1.
- core_yumi_i  in  1  core consumes the head word this cycle; legal only when core_valid_o=1.
- token_o  out  1  token line; each toggle returns `2^lg_credit_decimation_p` credits.
- overflow_o  out  1  sticky: a word arrived while the buffer was full.
- els_o  out  $clog2(els_p+1)  current occupancy, 0..els_p.

Behaviour:
- Reset: already decided — one clock, `clk_i`; reset `reset_n_i` is asynchronous and active-low.
  - While reset_n_i=0: read pointer, write pointer, occupancy and decimation counter are 0; token_o=0, overflow_o=0, core_valid_o=0, els_o=0.
  - core_data_o is don't-care during and after reset until the first write.
  - Deasserting reset mid-stream discards all buffered words.
- Enqueue:
  - io_valid_i=1 and occupancy<els_p: write io_data_i at wptr; wptr advances modulo els_p.
  - The word is visible on core_data_o / core_valid_o the next cycle (1-cycle latency); there is no bypass.
- Dequeue:
  - core_yumi_i=1: rptr advances modulo els_p; core_data_o presents the next entry combinationally from storage.
- Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance.
- Full:
  - Fullness is judged on the pre-cycle occupancy: io_valid_i=1 with occupancy==els_p is an overflow even if core_yumi_i=1 in the same cycle.
  - On overflow the word is dropped, overflow_o is set to 1, and it holds until reset.
- Empty: core_valid_o=0; core_yumi_i=1 while empty is illegal — assertion in simulation, ignored in RTL (no pointer movement, no credit).
- Credit:
  - The decimation counter (lg_credit_decimation_p bits) increments on each legal dequeue.
  - On the dequeue where the counter wraps from `2^lg_credit_decimation_p − 1` to 0, token_o toggles at that same clock edge (registered output).
  - Overflow-dropped words never generate credit.
- Occupancy: els_o = wptr−rptr with an extra wrap bit, so full (els_p) and empty (0) are distinguished; pointers carry `$clog2(els_p)+1` bits.
- Invariant (legal sender): tokens returned × `2^lg_credit_decimation_p` + occupancy + decimation count == words accepted + els_p − initial credit offset. The bench checks this every cycle.

Decomposition:
- Shared package `bsg_channel_token_pkg`: ptr width function; default channel width; the credit-decimation constant shared with the transmitter, so both ends agree on the credit unit.
- One natural sub-module, `bsg_channel_token_rx_buf`: a 1-write/1-read circular register array with pointers and occupancy.
  - The top level adds the overflow detect, the decimation counter and the token register.

Test Plan:
- Reset then idle 10 cycles → token_o=0, core_valid_o=0, els_o=0, overflow_o=0.
- Enqueue 0x11..0x14 on consecutive cycles with core_yumi_i=0 → els_o reaches 4; core_data_o=0x11 one cycle after the first write.
  - Then yumi 4 cycles → data 0x11,0x12,0x13,0x14 in order; token_o toggles once, on the 4th yumi edge.
- Fill with 16 words and hold yumi=0, then send a 17th word 0xAA → word dropped, overflow_o=1 sticky, els_o stays 16.
  - Draining 16 → exactly 4 token toggles, and 0xAA is never output.
- Full buffer with io_valid_i=1 and core_yumi_i=1 in the same cycle → overflow flagged, occupancy 15 afterwards.
- Continuous streaming, one enqueue and one yumi per cycle for 64 cycles → els_o constant, 16 token toggles, pointers wrap 4×, data order preserved.
- Assert reset_n_i=0 mid-stream with 7 words buffered and the decimation count at 3 → outputs clear immediately (async); after release a single yumi produces no toggle until 4 dequeues.
